// File: rtl/video_timing_pkg.sv
// Shared types, polarity constants and timing presets for the video timing generator.
// The preset struct uses the default counter width; non-default widths take fields directly.
package video_timing_pkg;

    localparam int unsigned CW_DEF = 16;

    localparam logic SYNC_POL_HIGH = 1'b1;
    localparam logic SYNC_POL_LOW  = 1'b0;

    typedef struct packed {
        logic [CW_DEF-1:0] h_active;
        logic [CW_DEF-1:0] h_fp;
        logic [CW_DEF-1:0] h_sync;
        logic [CW_DEF-1:0] h_bp;
        logic [CW_DEF-1:0] v_active;
        logic [CW_DEF-1:0] v_fp;
        logic [CW_DEF-1:0] v_sync;
        logic [CW_DEF-1:0] v_bp;
    } timing_cfg_t;

    localparam timing_cfg_t TIMING_1080P = '{
        h_active: 16'd1920, h_fp: 16'd88, h_sync: 16'd44, h_bp: 16'd148,
        v_active: 16'd1080, v_fp: 16'd4, v_sync: 16'd5, v_bp: 16'd36
    };

    localparam timing_cfg_t TIMING_720P = '{
        h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
        v_active: 16'd720, v_fp: 16'd5, v_sync: 16'd5, v_bp: 16'd20
    };

    localparam timing_cfg_t TIMING_TEST_SMALL = '{
        h_active: 16'd8, h_fp: 16'd2, h_sync: 16'd2, h_bp: 16'd2,
        v_active: 16'd4, v_fp: 16'd1, v_sync: 16'd1, v_bp: 16'd1
    };

    // Shift amount turning a beat index into the first pixel index of that beat.
    function automatic int unsigned ppc_shift(input int unsigned ppc);
        return (ppc >= 4) ? 2 : (ppc >= 2) ? 1 : 0;
    endfunction

endpackage

// File: rtl/vt_delay_line.sv
// Fixed-depth single-bit shift register with synchronous reset to a chosen idle level.
module vt_delay_line #(
    parameter int unsigned DLY     = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DLY-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {DLY{RST_VAL}};
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DLY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DLY-1];

endmodule

// File: rtl/video_timing_gen_p.sv
// Runtime-configurable video timing generator with shadowed config, early-valid lead,
// delayed sync/valid copies and frame/line markers. Outputs are registered from next counts.
module video_timing_gen_p
    import video_timing_pkg::*;
#(
    parameter int unsigned PPC      = 1,
    parameter int unsigned CW       = CW_DEF,
    parameter int unsigned PRE_LEAD = 2,
    parameter int unsigned DLY      = 2,
    parameter logic        HS_POL   = SYNC_POL_HIGH,
    parameter logic        VS_POL   = SYNC_POL_HIGH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    output logic          hsync_o,
    output logic          hsync_d_o,
    output logic          vsync_o,
    output logic          valid_h_o,
    output logic          pre_valid_h_o,
    output logic          valid_h_d_o,
    output logic          valid_v_o,
    output logic          de_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic [CW-1:0] frame_cnt_o
);

    localparam int unsigned TW  = CW + 2;
    localparam int unsigned XSH = ppc_shift(PPC);

    typedef struct packed {
        logic [CW-1:0] h_active;
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] v_active;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bp;
    } cfg_t;

    cfg_t          cfg_in, shadow_q, shadow_d, cur;
    logic          running_q;
    logic [CW-1:0] h_q, v_q, frame_q, h_d, v_d, frame_d;
    logic [TW-1:0] h_tot_s, v_tot_s, h_tot_c, v_tot_c;
    logic [TW-1:0] ha_c, va_c, hs_lo, hs_hi, vs_lo, vs_hi, h_dw, v_dw, hp_raw, hp;
    logic          h_last, v_last, start, ahead, vact_ahead, hs_act, vs_act;
    logic          hsync_n, vsync_n, valid_h_n, valid_v_n, pre_n, sof_n, eol_n;
    logic [CW-1:0] x_n, y_n;
    logic          hsync_q, vsync_q, valid_h_q, valid_v_q, pre_q, de_q, sof_q, eol_q;
    logic [CW-1:0] x_q, y_q;

    assign cfg_in = '{
        h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
        v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp
    };

    always_comb begin
        h_tot_s = TW'(shadow_q.h_active) + TW'(shadow_q.h_fp) + TW'(shadow_q.h_sync)
                + TW'(shadow_q.h_bp);
        v_tot_s = TW'(shadow_q.v_active) + TW'(shadow_q.v_fp) + TW'(shadow_q.v_sync)
                + TW'(shadow_q.v_bp);
        // ">=" keeps a zero-length total from stalling the counters.
        h_last  = (TW'(h_q) + TW'(1)) >= h_tot_s;
        v_last  = (TW'(v_q) + TW'(1)) >= v_tot_s;
        start   = en_i && (!running_q || (h_last && v_last));
        // The beat being produced belongs to a new frame whenever start is set.
        cur      = start ? cfg_in : shadow_q;
        shadow_d = (!en_i || start) ? cfg_in : shadow_q;

        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        if (!en_i || !running_q) begin
            h_d = '0;
            v_d = '0;
        end else if (h_last) begin
            h_d = '0;
            if (v_last) begin
                v_d     = '0;
                frame_d = frame_q + CW'(1);
            end else begin
                v_d = v_q + CW'(1);
            end
        end else begin
            h_d = h_q + CW'(1);
        end
    end

    always_comb begin
        h_tot_c = TW'(cur.h_active) + TW'(cur.h_fp) + TW'(cur.h_sync) + TW'(cur.h_bp);
        v_tot_c = TW'(cur.v_active) + TW'(cur.v_fp) + TW'(cur.v_sync) + TW'(cur.v_bp);
        ha_c    = TW'(cur.h_active);
        va_c    = TW'(cur.v_active);
        hs_lo   = ha_c + TW'(cur.h_fp);
        hs_hi   = hs_lo + TW'(cur.h_sync);
        vs_lo   = va_c + TW'(cur.v_fp);
        vs_hi   = vs_lo + TW'(cur.v_sync);
        h_dw    = TW'(h_d);
        v_dw    = TW'(v_d);

        valid_h_n = en_i && (h_dw < ha_c);
        valid_v_n = en_i && (v_dw < va_c);
        hs_act    = en_i && (h_dw >= hs_lo) && (h_dw < hs_hi);
        vs_act    = en_i && (v_dw >= vs_lo) && (v_dw < vs_hi);
        hsync_n   = hs_act ? HS_POL : ~HS_POL;
        vsync_n   = vs_act ? VS_POL : ~VS_POL;

        // Look PRE_LEAD beats ahead; a wrap lands on the following line.
        hp_raw = h_dw + TW'(PRE_LEAD);
        ahead  = hp_raw >= h_tot_c;
        hp     = ahead ? (hp_raw - h_tot_c) : hp_raw;
        if (!ahead) begin
            vact_ahead = v_dw < va_c;
        end else if ((v_dw + TW'(1)) >= v_tot_c) begin
            vact_ahead = 1'b1;
        end else begin
            vact_ahead = (v_dw + TW'(1)) < va_c;
        end
        pre_n = en_i && (hp < ha_c) && vact_ahead;

        sof_n = en_i && (h_d == '0) && (v_d == '0);
        eol_n = en_i && (h_dw == ha_c - TW'(1)) && (v_dw < va_c);
        x_n   = valid_h_n ? (h_d << XSH) : '0;
        y_n   = valid_v_n ? v_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= cfg_in;
            running_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            frame_q   <= '0;
            hsync_q   <= ~HS_POL;
            vsync_q   <= ~VS_POL;
            valid_h_q <= 1'b0;
            valid_v_q <= 1'b0;
            pre_q     <= 1'b0;
            de_q      <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            shadow_q  <= shadow_d;
            running_q <= en_i;
            h_q       <= h_d;
            v_q       <= v_d;
            frame_q   <= frame_d;
            hsync_q   <= hsync_n;
            vsync_q   <= vsync_n;
            valid_h_q <= valid_h_n;
            valid_v_q <= valid_v_n;
            pre_q     <= pre_n;
            de_q      <= valid_h_n & valid_v_n;
            sof_q     <= sof_n;
            eol_q     <= eol_n;
            x_q       <= x_n;
            y_q       <= y_n;
        end
    end

    vt_delay_line #(.DLY(DLY), .RST_VAL(~HS_POL)) u_hsync_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (hsync_q),
        .dout (hsync_d_o)
    );

    vt_delay_line #(.DLY(DLY), .RST_VAL(1'b0)) u_valid_h_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (valid_h_q),
        .dout (valid_h_d_o)
    );

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign valid_h_o     = valid_h_q;
    assign valid_v_o     = valid_v_q;
    assign pre_valid_h_o = pre_q;
    assign de_o          = de_q;
    assign sof_o         = sof_q;
    assign eol_o         = eol_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_cnt_o   = frame_q;

endmodule

// File: tb/tb_video_timing_gen_p.sv
// Directed bench for video_timing_gen_p: small timing config, PPC=4, PRE_LEAD=2, DLY=3,
// mid-frame config change, mid-frame reset and enable gating.
module tb_video_timing_gen_p;
    import video_timing_pkg::*;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_i;
    timing_cfg_t   cfg;
    logic          hsync_o, hsync_d_o, vsync_o, valid_h_o, pre_valid_h_o, valid_h_d_o;
    logic          valid_v_o, de_o, sof_o, eol_o;
    logic [CW-1:0] x_o, y_o, frame_cnt_o;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int hs_hist[3];
    int vh_hist[3];

    video_timing_gen_p #(
        .PPC(4), .CW(CW), .PRE_LEAD(2), .DLY(3), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .cfg_h_active  (cfg.h_active),
        .cfg_h_fp      (cfg.h_fp),
        .cfg_h_sync    (cfg.h_sync),
        .cfg_h_bp      (cfg.h_bp),
        .cfg_v_active  (cfg.v_active),
        .cfg_v_fp      (cfg.v_fp),
        .cfg_v_sync    (cfg.v_sync),
        .cfg_v_bp      (cfg.v_bp),
        .hsync_o       (hsync_o),
        .hsync_d_o     (hsync_d_o),
        .vsync_o       (vsync_o),
        .valid_h_o     (valid_h_o),
        .pre_valid_h_o (pre_valid_h_o),
        .valid_h_d_o   (valid_h_d_o),
        .valid_v_o     (valid_v_o),
        .de_o          (de_o),
        .sof_o         (sof_o),
        .eol_o         (eol_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) begin
            hs_hist[i] = 0;
            vh_hist[i] = 0;
        end
    endtask

    task automatic check_all(input string ph, input logic e_vh, input logic e_vv,
                             input logic e_hs, input logic e_vs, input logic e_pv,
                             input logic e_sof, input logic e_eol, input int e_x,
                             input int e_y, input int e_f);
        chk({ph, ".valid_h"}, 32'(valid_h_o), 32'(e_vh));
        chk({ph, ".valid_v"}, 32'(valid_v_o), 32'(e_vv));
        chk({ph, ".de"}, 32'(de_o), 32'(e_vh & e_vv));
        chk({ph, ".hsync"}, 32'(hsync_o), 32'(e_hs));
        chk({ph, ".vsync"}, 32'(vsync_o), 32'(e_vs));
        chk({ph, ".pre_valid"}, 32'(pre_valid_h_o), 32'(e_pv));
        chk({ph, ".sof"}, 32'(sof_o), 32'(e_sof));
        chk({ph, ".eol"}, 32'(eol_o), 32'(e_eol));
        chk({ph, ".x"}, 32'(x_o), e_x);
        chk({ph, ".y"}, 32'(y_o), e_y);
        chk({ph, ".frame_cnt"}, 32'(frame_cnt_o), e_f);
        chk({ph, ".hsync_d"}, 32'(hsync_d_o), hs_hist[2]);
        chk({ph, ".valid_h_d"}, 32'(valid_h_d_o), vh_hist[2]);
        hs_hist[2] = hs_hist[1];
        hs_hist[1] = hs_hist[0];
        hs_hist[0] = int'(e_hs);
        vh_hist[2] = vh_hist[1];
        vh_hist[1] = vh_hist[0];
        vh_hist[0] = int'(e_vh);
    endtask

    task automatic check_idle(input string ph);
        check_all(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Expected outputs for beat k of a run with HFP=HS=HBP=2, V timing 4/1/1/1.
    task automatic check_cycle(input string ph, input int k, input int ha, input int fbase);
        int   ht = ha + 6;
        int   h  = k % ht;
        int   v  = (k / ht) % 7;
        int   f  = fbase + k / (ht * 7);
        int   hp = h + 2;
        int   vl = v;
        logic vh, vv, hs, pv;
        if (hp >= ht) begin
            hp = hp - ht;
            vl = (v + 1) % 7;
        end
        vh = (h < ha);
        vv = (v < 4);
        hs = (h >= ha + 2) && (h < ha + 4);
        pv = (hp < ha) && (vl < 4);
        check_all(ph, vh, vv, hs, (v == 5), pv, (h == 0) && (v == 0),
                  (h == ha - 1) && vv, vh ? h * 4 : 0, vv ? v : 0, f);
    endtask

    initial begin
        clear_hist();
        rst  = 1'b1;
        en_i = 1'b1;
        cfg  = TIMING_TEST_SMALL;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;

        // Four frames at HA=8; HA is rewritten mid-frame 3 but must not apply until frame 4.
        for (int n = 0; n < 392; n++) begin
            if (n == 300) cfg.h_active = 16'd6;
            tick();
            check_cycle("ha8", n, 8, 0);
        end
        chk("ha8.frame_cnt_at_294_seen", 32'(frame_cnt_o), 3);

        for (int k = 0; k < 84; k++) begin
            tick();
            check_cycle("ha6", k, 6, 4);
        end

        // Run into frame 5 up to v_cnt=2, h_cnt=5, then reset.
        for (int k = 0; k < 30; k++) begin
            tick();
            check_cycle("pre_rst", k, 6, 5);
        end
        rst = 1'b1;
        tick();
        clear_hist();
        check_idle("mid_rst");
        rst  = 1'b0;
        en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("disabled");
        end

        en_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            check_cycle("restart", k, 6, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
